// File: rtl/dsa_lane_sched_if.sv
// rtl/dsa_lane_sched_if.sv - lane launch/completion bus between the scheduler and its workers
interface dsa_lane_sched_if #(
  parameter int LANES = 4,
  parameter int DIM_W = 16
);
  logic [LANES-1:0]       lane_start;
  logic [LANES*DIM_W-1:0] lane_row_first;
  logic [LANES*DIM_W-1:0] lane_row_last;
  logic [LANES-1:0]       lane_done;

  modport master (
    output lane_start,
    output lane_row_first,
    output lane_row_last,
    input  lane_done
  );

  modport slave (
    input  lane_start,
    input  lane_row_first,
    input  lane_row_last,
    output lane_done
  );
endinterface

// File: rtl/dsa_lane_sched.sv
// rtl/dsa_lane_sched.sv - multi-lane row scheduler for the bilinear DSA
module dsa_lane_sched #(
  parameter int LANES = 4,
  parameter int DIM_W = 16,
  parameter int CYC_W = 32,
  parameter int LN_W  = $clog2(LANES + 1)
) (
  input  logic                clk_50,
  input  logic                rst_n,
  input  logic                start_jtag,
  input  logic                start_sw,
  input  logic [DIM_W-1:0]    cfg_in_w,
  input  logic [DIM_W-1:0]    cfg_in_h,
  input  logic [15:0]         cfg_scale_q88,
  input  logic [LN_W-1:0]     cfg_lanes,
  dsa_lane_sched_if.master    lanes,
  output logic [DIM_W-1:0]    out_w,
  output logic [DIM_W-1:0]    out_h,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CYC_W-1:0]    cycle_count,
  output logic                led_done
);

  localparam int CNT_W = $clog2(DIM_W + LANES + 1);
  localparam int BW    = DIM_W + 4;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_DIV, S_ASSIGN, S_LAUNCH, S_RUN, S_FIN
  } state_t;

  state_t                 r_state;
  logic                   r_sw_s1, r_sw_s2, r_sw_d;
  logic [DIM_W-1:0]       r_in_w, r_in_h;
  logic [15:0]            r_scale;
  logic [LN_W-1:0]        r_n;
  logic [DIM_W-1:0]       r_out_w, r_out_h;
  logic [DIM_W-1:0]       r_dvd;
  logic [LN_W-1:0]        r_rem;
  logic [CNT_W-1:0]       r_cnt;
  logic [BW-1:0]          r_base;
  logic [LANES-1:0]       r_active, r_pending, r_lane_start;
  logic [LANES*DIM_W-1:0] r_first, r_last;
  logic                   r_busy, r_done, r_err;
  logic [CYC_W-1:0]       r_cyc;

  logic                   w_sw_edge, w_start_req;
  logic [DIM_W+15:0]      w_prod_w, w_prod_h;
  logic [DIM_W-1:0]       w_ow, w_oh;
  logic                   w_cfg_err;
  logic [LN_W-1:0]        w_n_cfg;
  logic [LN_W:0]          w_trial, w_diff;
  logic                   w_ge;
  logic [LN_W-1:0]        w_rem_nx;
  logic [DIM_W-1:0]       w_rpl, w_hi;
  logic [BW-1:0]          w_end;
  logic                   w_act;
  logic [LANES-1:0]       w_act_mask, w_pend_nx;
  logic                   w_unused;

  assign w_sw_edge   = r_sw_s2 & ~r_sw_d;
  assign w_start_req = start_jtag | w_sw_edge;

  assign w_prod_w  = (DIM_W+16)'(r_in_w) * (DIM_W+16)'(r_scale);
  assign w_prod_h  = (DIM_W+16)'(r_in_h) * (DIM_W+16)'(r_scale);
  assign w_ow      = w_prod_w[8 +: DIM_W];
  assign w_oh      = w_prod_h[8 +: DIM_W];
  assign w_cfg_err = (r_in_w < DIM_W'(2)) || (r_in_h < DIM_W'(2)) || (r_scale == 16'd0) ||
                     (w_ow == '0) || (w_oh == '0);
  assign w_n_cfg   = (cfg_lanes == '0 || cfg_lanes > LN_W'(LANES)) ? LN_W'(LANES) : cfg_lanes;
  assign w_unused  = ^{w_prod_w[7:0], w_prod_w[DIM_W+15:DIM_W+8],
                       w_prod_h[7:0], w_prod_h[DIM_W+15:DIM_W+8], w_diff[LN_W]};

  // Divider computes floor((out_h-1)/N); adding one gives the ceiling without a wider dividend.
  assign w_trial  = {r_rem, r_dvd[DIM_W-1]};
  assign w_diff   = w_trial - {1'b0, r_n};
  assign w_ge     = (w_trial >= {1'b0, r_n});
  assign w_rem_nx = w_ge ? w_diff[LN_W-1:0] : w_trial[LN_W-1:0];
  assign w_rpl    = r_dvd + DIM_W'(1);

  assign w_end = r_base + BW'(w_rpl);
  assign w_act = (r_cnt < CNT_W'(r_n)) && (r_base < BW'(r_out_h));
  assign w_hi  = (w_end > BW'(r_out_h)) ? r_out_h : w_end[DIM_W-1:0];

  always_comb begin
    w_act_mask = r_active;
    for (int i = 0; i < LANES; i++) begin
      if (w_act && (r_cnt == CNT_W'(i))) w_act_mask[i] = 1'b1;
    end
  end

  assign w_pend_nx = r_pending & ~lanes.lane_done;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sw_s1      <= 1'b0;
      r_sw_s2      <= 1'b0;
      r_sw_d       <= 1'b0;
      r_in_w       <= '0;
      r_in_h       <= '0;
      r_scale      <= '0;
      r_n          <= '0;
      r_out_w      <= '0;
      r_out_h      <= '0;
      r_dvd        <= '0;
      r_rem        <= '0;
      r_cnt        <= '0;
      r_base       <= '0;
      r_active     <= '0;
      r_pending    <= '0;
      r_lane_start <= '0;
      r_first      <= '0;
      r_last       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cyc        <= '0;
    end else begin
      r_sw_s1 <= start_sw;
      r_sw_s2 <= r_sw_s1;
      r_sw_d  <= r_sw_s2;
      if (r_busy) r_cyc <= r_cyc + CYC_W'(1);

      case (r_state)
        S_IDLE: begin
          if (w_start_req) begin
            r_in_w   <= cfg_in_w;
            r_in_h   <= cfg_in_h;
            r_scale  <= cfg_scale_q88;
            r_n      <= w_n_cfg;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cyc    <= '0;
            r_busy   <= 1'b1;
            r_active <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_out_w <= w_ow;
          r_out_h <= w_oh;
          r_dvd   <= w_oh - DIM_W'(1);
          r_rem   <= '0;
          r_cnt   <= '0;
          if (w_cfg_err) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nx;
          r_dvd <= {r_dvd[DIM_W-2:0], w_ge};
          if (r_cnt == CNT_W'(DIM_W - 1)) begin
            r_cnt   <= '0;
            r_base  <= '0;
            r_state <= S_ASSIGN;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ASSIGN: begin
          for (int i = 0; i < LANES; i++) begin
            if (r_cnt == CNT_W'(i)) begin
              r_first[i*DIM_W +: DIM_W] <= w_act ? r_base[DIM_W-1:0] : '0;
              r_last[i*DIM_W +: DIM_W]  <= w_act ? (w_hi - DIM_W'(1)) : '0;
            end
          end
          r_active <= w_act_mask;
          r_base   <= w_end;
          if (r_cnt == CNT_W'(LANES - 1)) begin
            r_lane_start <= w_act_mask;
            r_state      <= S_LAUNCH;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_LAUNCH: begin
          // Done pulses seen during launch are dropped: pending is loaded only now.
          r_lane_start <= '0;
          r_pending    <= r_active;
          r_state      <= S_RUN;
        end
        S_RUN: begin
          r_pending <= w_pend_nx;
          if (w_pend_nx == '0) r_state <= S_FIN;
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lanes.lane_start     = r_lane_start;
  assign lanes.lane_row_first = r_first;
  assign lanes.lane_row_last  = r_last;
  assign out_w       = r_out_w;
  assign out_h       = r_out_h;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign cycle_count = r_cyc;
  assign led_done    = r_done;

endmodule

// File: tb/tb_dsa_lane_sched.sv
// tb/tb_dsa_lane_sched.sv - scoreboard bench for dsa_lane_sched with a reference job model
module tb_dsa_lane_sched;

  logic        clk_50;
  logic        rst_n;
  logic        start_jtag;
  logic        start_sw;
  logic [15:0] cfg_in_w, cfg_in_h, cfg_scale_q88;
  logic [2:0]  cfg_lanes;
  logic [15:0] out_w, out_h;
  logic        busy, done, err, led_done;
  logic [31:0] cycle_count;

  dsa_lane_sched_if #(.LANES(4), .DIM_W(16)) lif ();

  dsa_lane_sched #(.LANES(4), .DIM_W(16), .CYC_W(32)) dut (
    .clk_50        (clk_50),
    .rst_n         (rst_n),
    .start_jtag    (start_jtag),
    .start_sw      (start_sw),
    .cfg_in_w      (cfg_in_w),
    .cfg_in_h      (cfg_in_h),
    .cfg_scale_q88 (cfg_scale_q88),
    .cfg_lanes     (cfg_lanes),
    .lanes         (lif),
    .out_w         (out_w),
    .out_h         (out_h),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .cycle_count   (cycle_count),
    .led_done      (led_done)
  );

  typedef struct {
    bit          is_err;
    logic [3:0]  mask;
    logic [63:0] first;
    logic [63:0] last;
    int          ow;
    int          oh;
    int          t;
    int          start_cyc;
    int          done_cyc;
    int          cycc;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   wdly[4];
  int   job_l = 0;
  bit   job_on = 0;
  bit   p_busy, p_done, p_err, m_started;

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference job: plain arithmetic from the scheduling rules.
  function automatic exp_t build(input int iw, input int ih, input int sc, input int ln, input int t);
    exp_t   e;
    longint pw, ph;
    int     n, rpl, f, l, dmax;
    e = '{default: 0};
    pw = (longint'(iw) * sc) >> 8;
    ph = (longint'(ih) * sc) >> 8;
    e.ow = int'(pw & 'hFFFF);
    e.oh = int'(ph & 'hFFFF);
    e.is_err = (iw < 2) || (ih < 2) || (sc == 0) || (e.ow == 0) || (e.oh == 0);
    n = (ln == 0 || ln > 4) ? 4 : ln;
    rpl = (e.oh + n - 1) / n;
    dmax = 0;
    for (int i = 0; i < 4; i++) begin
      f = i * rpl;
      if (!e.is_err && i < n && f < e.oh) begin
        l = ((f + rpl < e.oh) ? f + rpl : e.oh) - 1;
        e.mask[i] = 1'b1;
        e.first[i*16 +: 16] = 16'(f);
        e.last[i*16 +: 16]  = 16'(l);
        if (wdly[i] > dmax) dmax = wdly[i];
      end
    end
    e.t = t;
    e.start_cyc = t + 22;
    e.done_cyc  = t + 22 + dmax + 2;
    e.cycc      = 22 + dmax + 1;
    return e;
  endfunction

  task automatic rand_dly();
    for (int i = 0; i < 4; i++) wdly[i] = $urandom_range(1, 12);
  endtask

  task automatic issue(input int iw, input int ih, input int sc, input int ln, input bit sw);
    exp_t e;
    int   t;
    @(posedge clk_50); #1;
    cfg_in_w = 16'(iw); cfg_in_h = 16'(ih); cfg_scale_q88 = 16'(sc); cfg_lanes = 3'(ln);
    t = sw ? cyc + 2 : cyc;
    e = build(iw, ih, sc, ln, t);
    // Inactive lanes may pulse anytime, even in the launch cycle; those pulses must be ignored.
    for (int i = 0; i < 4; i++) if (!e.mask[i]) wdly[i] = $urandom_range(0, 12);
    exp_q.push_back(e);
    job_l  = t + 22;
    job_on = !e.is_err;
    if (sw) start_sw = 1'b1; else start_jtag = 1'b1;
    @(posedge clk_50); #1;
    start_jtag = 1'b0;
    if (sw) repeat (2) @(posedge clk_50);
    #1;
    cfg_in_w = 16'($urandom); cfg_in_h = 16'($urandom);
    cfg_scale_q88 = 16'($urandom); cfg_lanes = 3'($urandom);
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk_50);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("job_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (15) @(posedge clk_50);
    job_on = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    for (int k = 0; k < 200 && cyc < target; k++) @(posedge clk_50);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_led"}, led_done, 0);
    chk({tag, "_cyc"}, cycle_count, 0);
    chk({tag, "_ow"}, out_w, 0);
    chk({tag, "_oh"}, out_h, 0);
    chk({tag, "_start"}, lif.lane_start, 0);
    chk({tag, "_first"}, lif.lane_row_first, 0);
    chk({tag, "_last"}, lif.lane_row_last, 0);
  endtask

  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    exp_q.delete();
    job_on = 1'b0;
    @(posedge clk_50); #1;
    rst_n = 1'b1;
  endtask

  // Worker lanes: each pulses lane_done once, wdly[i] cycles after the expected launch.
  initial begin
    lif.lane_done = '0;
    forever begin
      @(posedge clk_50); #1;
      for (int i = 0; i < 4; i++) lif.lane_done[i] = job_on && (cyc == job_l + wdly[i]);
    end
  end

  // Monitor: compares DUT events against the head of the scoreboard queue.
  initial begin
    p_busy = 0; p_done = 0; p_err = 0; m_started = 0;
    forever begin
      @(negedge clk_50);
      if (!rst_n) begin
        p_busy = 0; p_done = 0; p_err = 0; m_started = 0;
      end else begin
        if (busy && !p_busy) begin
          if (exp_q.size() == 0) chk("busy_unexpected_q", exp_q.size(), 1);
          else chk("busy_rise_cyc", cyc, exp_q[0].t + 1);
        end
        if (lif.lane_start != 0) begin
          if (exp_q.size() == 0) chk("start_unexpected_q", exp_q.size(), 1);
          else begin
            m_e = exp_q[0];
            m_started = 1;
            chk("start_on_err_job", m_e.is_err, 0);
            chk("start_mask", lif.lane_start, m_e.mask);
            chk("start_cyc", cyc, m_e.start_cyc);
            chk("start_first", lif.lane_row_first, m_e.first);
            chk("start_last", lif.lane_row_last, m_e.last);
            chk("start_out_w", out_w, m_e.ow);
            chk("start_out_h", out_h, m_e.oh);
          end
        end
        if (done && !p_done) begin
          if (exp_q.size() == 0) chk("done_unexpected_q", exp_q.size(), 1);
          else begin
            m_e = exp_q.pop_front();
            chk("done_kind", m_e.is_err, 0);
            chk("done_after_start", m_started, 1);
            chk("done_cyc", cyc, m_e.done_cyc);
            chk("done_cycle_count", cycle_count, m_e.cycc);
            chk("done_busy", busy, 0);
            chk("done_err", err, 0);
            chk("done_led", led_done, 1);
            chk("done_first_hold", lif.lane_row_first, m_e.first);
            chk("done_last_hold", lif.lane_row_last, m_e.last);
            m_started = 0;
          end
        end
        if (err && !p_err) begin
          if (exp_q.size() == 0) chk("err_unexpected_q", exp_q.size(), 1);
          else begin
            m_e = exp_q.pop_front();
            chk("err_kind", m_e.is_err, 1);
            chk("err_cyc", cyc, m_e.t + 2);
            chk("err_done", done, 0);
            chk("err_busy", busy, 0);
            chk("err_no_start", m_started, 0);
            m_started = 0;
          end
        end
        p_busy = busy; p_done = done; p_err = err;
      end
    end
  end

  initial begin
    rst_n = 1'b0; start_jtag = 1'b0; start_sw = 1'b0;
    cfg_in_w = '0; cfg_in_h = '0; cfg_scale_q88 = '0; cfg_lanes = '0;
    for (int i = 0; i < 4; i++) wdly[i] = 1;
    repeat (3) @(posedge clk_50);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk_50);
    #1;
    check_zero("post_reset");

    // Even split with staggered completion.
    wdly = '{2, 7, 4, 10};
    issue(64, 64, 'h0200, 4, 0);
    wait_done();

    // Uneven split: lane 3 left idle.
    rand_dly();
    issue(10, 10, 'h0080, 4, 0);
    wait_done();

    // Invalid configurations.
    issue(64, 64, 'h0000, 4, 0);
    wait_done();
    issue(1, 64, 'h0100, 4, 0);
    wait_done();

    // Start during RUN, lanes 1 and 2 finishing together last.
    wdly = '{3, 5, 5, 1};
    issue(64, 64, 'h0200, 4, 0);
    wait_cyc(job_l + 2);
    start_jtag = 1'b1;
    @(posedge clk_50); #1;
    start_jtag = 1'b0;
    wait_done();

    // Reset during DIV, then during RUN, then a clean job.
    rand_dly();
    issue(64, 64, 'h0200, 4, 0);
    wait_cyc(exp_q[0].t + 6);
    reset_now("rst_div");
    rand_dly();
    issue(40, 30, 'h0180, 3, 0);
    wait_cyc(job_l + 2);
    reset_now("rst_run");
    rand_dly();
    issue(64, 64, 'h0200, 4, 0);
    wait_done();

    // Switch start held high for 100 cycles, lanes defaulting to all.
    rand_dly();
    issue(50, 37, 'h0140, 0, 1);
    repeat (97) @(posedge clk_50);
    #1;
    start_sw = 1'b0;
    wait_done();

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      rand_dly();
      issue($urandom_range(0, 150), $urandom_range(0, 150), $urandom_range(0, 'h300),
            $urandom_range(0, 7), 0);
      wait_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dsa_lane_sched.md
# dsa_lane_sched

Multi-lane job scheduler for the bilinear DSA. It sits between the JTAG config bridge, the start switch and `LANES` parallel bilinear workers. On start it snapshots the configuration, computes output dimensions in Q8.8, and splits output rows into contiguous per-lane ranges. It then launches the lanes, aggregates their completion and reports `busy`, `done`, `err` and a cycle count.

## Interface
- `LANES`, 4: number of worker lanes (1..8)
- `DIM_W`, 16: width of image dimensions and row indices
- `CYC_W`, 32: width of the performance cycle counter
- `LN_W`, $clog2(LANES+1): width of `cfg_lanes`

- `clk_50` in 1: system clock; only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_jtag` in 1: one-cycle start pulse, synchronous to `clk_50`.
- `start_sw` in 1: asynchronous board switch; a rising edge starts a job.
- `cfg_in_w`, `cfg_in_h` in DIM_W: input width and height.
- `cfg_scale_q88` in 16: scale factor, unsigned Q8.8.
- `cfg_lanes` in LN_W: lanes to use; 0 or >LANES means LANES.
- `lane_start` out LANES: one-cycle start pulse per lane.
- `lane_row_first`, `lane_row_last` out LANES*DIM_W: inclusive row range per lane; lane i occupies bits [i*DIM_W +: DIM_W].
- `lane_done` in LANES: one-cycle completion pulse per lane.
- `out_w`, `out_h` out DIM_W: computed output dimensions.
- `busy` out 1: job in progress.
- `done` out 1: sticky job-complete flag.
- `err` out 1: sticky configuration-error flag.
- `cycle_count` out CYC_W: job duration in cycles.
- `led_done` out 1: equal to `done`.

## Operation
- **Reset:** every output is 0 and the FSM is in IDLE.
- **start_sw path:** two-flop synchroniser, then a rising-edge detect register.
- **Start condition:** `start_req = start_jtag | sw_edge`.
- **Accepting a start:** a request is accepted only in IDLE. Accept snapshots all `cfg_*`, clears `done`, `err` and `cycle_count`, and moves to CALC. Requests in any other state are ignored. Changes to `cfg_*` after accept have no effect.
- **FSM:** IDLE → CALC → DIV → ASSIGN → LAUNCH → RUN → FIN → IDLE. CALC goes to IDLE directly on a config error.
- **CALC (1 cycle):**
  - `out_w = (in_w*scale) >> 8` and `out_h = (in_h*scale) >> 8`; 32-bit products, truncated to DIM_W.
  - Error if `in_w < 2`, `in_h < 2`, `scale == 0`, `out_w == 0` or `out_h == 0`.
  - On error: set `err`, do not set `done`, issue no `lane_start`.
  - Resolve the effective lane count N.
- **DIV (DIM_W cycles):** restoring divider, `rpl = ceil(out_h / N)`, computed as `(out_h + N - 1) / N`.
- **ASSIGN (LANES cycles):** one lane per cycle, using an accumulated base, not a multiplier.
  - `first_i = i*rpl`, `last_i = min(first_i + rpl, out_h) - 1`.
  - A lane is active when `i < N` and `first_i < out_h`.
  - Inactive lanes get `first = last = 0`.
- **LAUNCH (1 cycle):** `lane_start[i] = 1` for every active lane, all in the same cycle. Load the pending mask with the active lanes.
- **RUN:**
  - `lane_done[i]` clears pending bit i. Multiple simultaneous pulses clear together.
  - Pulses for non-pending lanes, including any in the LAUNCH cycle, are ignored.
  - When the mask reaches 0, go to FIN on the next cycle.
- **FIN (1 cycle):** set `done`, then go to IDLE.
- **busy:** 1 in CALC through FIN inclusive.
- **cycle_count:** increments every cycle `busy` is 1; holds its value otherwise.
- **Output hold:** `out_w`, `out_h` and the row ranges hold until the next accept.

## Timing
- `start_jtag` sampled high in IDLE at cycle T:
  - `busy` = 1 from T+1.
  - `lane_start` at T+2+DIM_W+LANES (T+22 with defaults).
- A `start_sw` rising edge is recognised 2 cycles later than an equivalent `start_jtag` pulse.
- Last `lane_done` at cycle D: FIN at D+1, `done` = 1 and `busy` = 0 from D+2.
- Config error: `err` = 1 and `busy` = 0 from T+2.
- `rst_n` low mid-job: immediate asynchronous return to reset values, `lane_start` forced to 0. Lanes share `rst_n`.

## Test plan
- **Even split.** Stimulus: 64×64, scale 0x0200, `cfg_lanes` = 4; lanes finish at staggered times. Required: `out_w` = `out_h` = 128; ranges 0–31, 32–63, 64–95, 96–127; `lane_start` = 4'b1111 at T+22; `done` two cycles after the last `lane_done`; `cycle_count` = busy cycles.
- **Uneven split.** Stimulus: 10×10, scale 0x0080, `cfg_lanes` = 4. Required: `out_h` = 5, rpl = 2; ranges [0,1], [2,3], [4,4]; lane 3 never started; `done` after three dones.
- **Invalid config.** Stimulus: scale 0x0000, then separately `in_w` = 1. Required: `err` = 1, `done` = 0, `lane_start` never asserted, `busy` low at T+2.
- **Start and done collisions.** Stimulus: `start_jtag` during RUN, and `lane_done` on lanes 1 and 2 in the same cycle. Required: the start is ignored, ranges are unchanged, both pending bits clear, and completion is on schedule.
- **Reset mid-job.** Stimulus: `rst_n` low during DIV and again during RUN, followed by a new start. Required: all outputs 0 immediately; the next job runs normally with `cycle_count` starting from 0.
- **Switch start.** Stimulus: `start_sw` rises and stays high for 100 cycles. Required: exactly one job, with `lane_start` 2 cycles later than the JTAG case; `cfg_lanes` = 0 behaves as LANES.
